// File: rtl/alu_issue_pkg.sv
// Shared constants for the alu issue stage: alu control-code layout and response buffer sizing.
package alu_issue_pkg;
    localparam int           ALU_PI_W   = 4;
    localparam logic [3:0]   IDLE_CODE  = 4'b0000;
    localparam int           PI_INHIBIT = 1;
    localparam int           PI_A       = 2;
    localparam int           PI_B       = 3;
    localparam int           RSP_DEPTH  = 2;
    // Response entry is packed {result, echo, tag}; these are its non-tag bits above the tag.
    localparam int           RSP_META_W = 2;
endpackage

// File: rtl/alu_issue_if.sv
// Request, alu and response signals of the issue stage; slave is the stage, master its environment.
interface alu_issue_if
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    logic                    req_valid;
    logic                    req_ready;
    logic [ALU_PI_W-1:0]     req_data;
    logic [TAG_W-1:0]        req_tag;
    logic [ALU_PI_W-1:0]     alu_pi;
    logic                    alu_po0;
    logic                    alu_po1;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic                    rsp_result;
    logic                    rsp_echo;
    logic [TAG_W-1:0]        rsp_tag;
    logic [$clog2(DEPTH):0]  occupancy;

    modport slave (
        input  req_valid, req_data, req_tag, alu_po0, alu_po1, rsp_ready,
        output req_ready, alu_pi, rsp_valid, rsp_result, rsp_echo, rsp_tag, occupancy
    );

    modport master (
        output req_valid, req_data, req_tag, alu_po0, alu_po1, rsp_ready,
        input  req_ready, alu_pi, rsp_valid, rsp_result, rsp_echo, rsp_tag, occupancy
    );
endinterface

// File: rtl/alu_issue_fifo.sv
// Generic synchronous FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module alu_issue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        wdata_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/alu_issue_stage.sv
// Queues tagged alu control codes, issues one per cycle under a 2-slot response credit,
// and pairs each registered alu result with its tag and echo for in-order return.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic      clock,
    input  logic      reset,
    alu_issue_if.slave bus
);
    localparam int CNT_W     = $clog2(DEPTH) + 1;
    localparam int RSP_CNT_W = $clog2(RSP_DEPTH) + 1;

    typedef struct packed {
        logic [ALU_PI_W-1:0] data;
        logic [TAG_W-1:0]    tag;
    } req_entry_t;

    typedef struct packed {
        logic             result;
        logic             echo;
        logic [TAG_W-1:0] tag;
    } rsp_entry_t;

    req_entry_t           req_wdata, req_head;
    logic                 req_push, req_full, req_empty;
    logic [CNT_W-1:0]     req_count;
    rsp_entry_t           rsp_wdata, rsp_head;
    logic                 rsp_push, rsp_pop, rsp_full, rsp_empty;
    logic [RSP_CNT_W-1:0] rsp_count;
    logic                 issue;
    logic [2:0]           credits_used;
    logic                 inflight_q, inflight_d;
    logic [TAG_W-1:0]     cap_tag_q, cap_tag_d;
    logic                 cap_echo_q, cap_echo_d;

    assign bus.req_ready = ~reset & ~req_full;
    assign req_push      = bus.req_valid & bus.req_ready;
    assign req_wdata     = '{data: bus.req_data, tag: bus.req_tag};
    assign bus.occupancy = reset ? '0 : req_count;

    assign bus.rsp_valid  = ~reset & ~rsp_empty;
    assign rsp_pop        = bus.rsp_valid & bus.rsp_ready;
    assign bus.rsp_result = rsp_head.result;
    assign bus.rsp_echo   = rsp_head.echo;
    assign bus.rsp_tag    = rsp_head.tag;

    // A slot freed by this cycle's response pop can be reused at once, hence the
    // combinational path from rsp_ready to alu_pi.
    assign credits_used = 3'(rsp_count) + {2'b00, inflight_q} - {2'b00, rsp_pop};
    assign issue        = ~reset & ~req_empty & (credits_used < 3'd2);
    assign bus.alu_pi   = issue ? req_head.data : IDLE_CODE;

    // alu_po0 only means something the cycle after an issue.
    assign rsp_push  = inflight_q & ~rsp_full;
    assign rsp_wdata = '{result: bus.alu_po0, echo: cap_echo_q, tag: cap_tag_q};

    always_comb begin
        inflight_d = issue;
        cap_tag_d  = cap_tag_q;
        cap_echo_d = cap_echo_q;
        if (issue) begin
            cap_tag_d  = req_head.tag;
            cap_echo_d = bus.alu_po1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_q <= 1'b0;
            cap_tag_q  <= '0;
            cap_echo_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            cap_tag_q  <= cap_tag_d;
            cap_echo_q <= cap_echo_d;
        end
    end

    alu_issue_fifo #(.WIDTH(ALU_PI_W + TAG_W), .DEPTH(DEPTH)) u_req_q (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (req_push),
        .wdata_i (req_wdata),
        .pop_i   (issue),
        .rdata_o (req_head),
        .full_o  (req_full),
        .empty_o (req_empty),
        .count_o (req_count)
    );

    alu_issue_fifo #(.WIDTH(RSP_META_W + TAG_W), .DEPTH(RSP_DEPTH)) u_rsp_q (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (rsp_push),
        .wdata_i (rsp_wdata),
        .pop_i   (rsp_pop),
        .rdata_o (rsp_head),
        .full_o  (rsp_full),
        .empty_o (rsp_empty),
        .count_o (rsp_count)
    );
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a small alu model plus an in-order scoreboard of expected responses.
module tb_alu_issue_stage;
    import alu_issue_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic             result;
        logic             echo;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;
    int   rsp_pops = 0;
    exp_t exp_q[$];
    exp_t e;
    logic [3:0] bp_data [6];

    always #5 clock = ~clock;

    alu_issue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    alu_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // alu model: registered A & B & ~inhibit, combinational echo of A
    always @(posedge clock)
        bus.alu_po0 <= bus.alu_pi[PI_B] & bus.alu_pi[PI_A] & ~bus.alu_pi[PI_INHIBIT];
    assign bus.alu_po1 = bus.alu_pi[PI_A];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (bus.req_valid && bus.req_ready)
                exp_q.push_back('{result: bus.req_data[PI_B] & bus.req_data[PI_A] & ~bus.req_data[PI_INHIBIT],
                                  echo:   bus.req_data[PI_A],
                                  tag:    bus.req_tag});
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_pops++;
                chk("sb_rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_result", 32'(bus.rsp_result), 32'(e.result));
                    chk("sb_echo",   32'(bus.rsp_echo),   32'(e.echo));
                    chk("sb_tag",    32'(bus.rsp_tag),    32'(e.tag));
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_req(input logic [3:0] d, input logic [TAG_W-1:0] t);
        int k;
        step();
        bus.req_valid = 1'b1;
        bus.req_data  = d;
        bus.req_tag   = t;
        @(negedge clock);
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("push_accept_timeout", 32'(k < 20), 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clock);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bp_data[0] = 4'b1100; bp_data[1] = 4'b1110; bp_data[2] = 4'b0100;
        bp_data[3] = 4'b1000; bp_data[4] = 4'b1101; bp_data[5] = 4'b0110;
        reset         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_data  = 4'b1111;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b0;

        // reset held two cycles with a pending request
        step();
        step();
        @(negedge clock);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_alu_pi",    32'(bus.alu_pi),    32'd0);
        chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
        step();
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        chk("rel_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rel_occupancy", 32'(bus.occupancy), 32'd0);

        // single request latency
        push_req(4'b1100, 4'd5);
        step(); bus.req_valid = 1'b0;
        @(negedge clock);
        chk("single_alu_pi", 32'(bus.alu_pi), 32'b1100);
        step(); @(negedge clock);
        chk("single_c2_idle", 32'(bus.rsp_valid), 32'd0);
        step(); @(negedge clock);
        chk("single_c3_valid", 32'(bus.rsp_valid), 32'd1);
        chk("single_c3_tag",   32'(bus.rsp_tag),   32'd5);
        chk("single_c3_result", 32'(bus.rsp_result), 32'd1);
        step();
        drain("single_drain");

        // back-to-back stream, one response per cycle in cycles 3..10
        for (int c = 0; c < 12; c++) begin
            step();
            bus.req_valid = (c < 8);
            bus.req_data  = 4'b1110;
            bus.req_tag   = TAG_W'(c);
            @(negedge clock);
            if (c < 8) chk("stream_req_ready", 32'(bus.req_ready), 32'd1);
            if (c >= 3 && c <= 10) begin
                chk("stream_rsp_valid", 32'(bus.rsp_valid), 32'd1);
                chk("stream_rsp_tag",   32'(bus.rsp_tag),   32'(c - 3));
            end
        end
        drain("stream_drain");

        // backpressure: DEPTH+2 requests with the consumer stalled
        step();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) push_req(bp_data[i], TAG_W'(i));
        for (int i = 0; i < 2; i++) begin
            step();
            bus.req_valid = 1'b0;
            @(negedge clock);
            chk("bp_occupancy", 32'(bus.occupancy), 32'(DEPTH));
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_alu_idle",  32'(bus.alu_pi),    32'd0);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_hold",  32'(bus.rsp_tag),   32'd0);
        end

        // full queue while an issue happens: push refused now, accepted next cycle
        p0 = rsp_pops;
        step();
        bus.req_valid = 1'b1;
        bus.req_data  = 4'b1010;
        bus.req_tag   = TAG_W'(6);
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        chk("full_refuse",   32'(bus.req_ready), 32'd0);
        chk("full_issue_pi", 32'(bus.alu_pi),    32'(bp_data[2]));
        step();
        @(negedge clock);
        chk("full_accept_next", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 1'b0;
        drain("bp_drain");
        chk("bp_rsp_count", 32'(rsp_pops - p0), 32'(DEPTH + 3));

        // reset with queued, in-flight and buffered work
        step();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) push_req(bp_data[i], TAG_W'(i));
        step(); bus.req_valid = 1'b0;
        step();
        step(); bus.rsp_ready = 1'b1;
        step(); bus.rsp_ready = 1'b0; reset = 1'b1;
        step(); reset = 1'b0; bus.rsp_ready = 1'b1;
        p0 = rsp_pops;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("midrst_quiet", 32'(bus.rsp_valid), 32'd0);
            step();
        end
        chk("midrst_occupancy", 32'(bus.occupancy), 32'd0);
        chk("midrst_no_rsp", 32'(rsp_pops - p0), 32'd0);
        push_req(4'b1100, 4'd9);
        step(); bus.req_valid = 1'b0;
        step(); @(negedge clock);
        chk("midrst_t2_idle", 32'(bus.rsp_valid), 32'd0);
        step(); @(negedge clock);
        chk("midrst_t3_valid",  32'(bus.rsp_valid),  32'd1);
        chk("midrst_t3_tag",    32'(bus.rsp_tag),    32'd9);
        chk("midrst_t3_result", 32'(bus.rsp_result), 32'd1);
        step();
        drain("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
